// File: rtl/upsample_param.sv
// Interpolating upsampler: each accepted sample becomes an L-sample burst,
// either zero-stuffed or held, with valid/ready flow control on both sides.
module upsample_param #(
  parameter int WIDTH = 32,
  parameter int LMAX  = 8,
  parameter int LW    = $clog2(LMAX) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LW-1:0]           l_factor,
  input  logic                    mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_first,
  output logic                    out_last
);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t                  r_state;
  logic signed [WIDTH-1:0] r_out_data;
  logic signed [WIDTH-1:0] r_hold;
  logic                    r_first;
  logic                    r_last;
  logic                    r_mode;
  logic [LW-1:0]           r_phase;
  logic [LW-1:0]           r_l;

  logic                    w_accept;
  logic                    w_xfer;
  logic [LW-1:0]           w_l_clamped;
  logic [LW-1:0]           w_phase_nxt;

  function automatic logic [LW-1:0] clamp_factor(input logic [LW-1:0] f);
    if (f == '0)
      return LW'(1);
    if (f > LW'(LMAX))
      return LW'(LMAX);
    return f;
  endfunction

  function automatic logic signed [WIDTH-1:0] fill_sample(input logic       hold_mode,
                                                          input logic signed [WIDTH-1:0] held);
    return hold_mode ? held : '0;
  endfunction

  // A new sample may enter while idle, or as the last phase of the current burst leaves.
  assign out_valid   = (r_state == S_BURST);
  assign in_ready    = !out_valid || (out_ready && r_last);
  assign w_accept    = in_valid && in_ready;
  assign w_xfer      = out_valid && out_ready;
  assign w_l_clamped = clamp_factor(l_factor);
  assign w_phase_nxt = r_phase + LW'(1);

  assign out_data  = r_out_data;
  assign out_first = r_first;
  assign out_last  = r_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_out_data <= '0;
      r_first    <= 1'b0;
      r_last     <= 1'b0;
      r_phase    <= '0;
      r_l        <= LW'(1);
      r_mode     <= 1'b0;
    end else if (w_accept) begin
      r_state    <= S_BURST;
      r_out_data <= in_data;
      r_first    <= 1'b1;
      r_last     <= (w_l_clamped == LW'(1));
      r_phase    <= '0;
      r_l        <= w_l_clamped;
      r_mode     <= mode;
    end else if (w_xfer) begin
      if (r_last) begin
        // Burst drained with nothing waiting: out_data keeps its last value.
        r_state <= S_IDLE;
        r_first <= 1'b0;
        r_last  <= 1'b0;
      end else begin
        r_phase    <= w_phase_nxt;
        r_out_data <= fill_sample(r_mode, r_hold);
        r_first    <= 1'b0;
        r_last     <= (w_phase_nxt == r_l - LW'(1));
      end
    end
  end

  // Held sample is pure data; it is only read after the accept that loads it.
  always_ff @(posedge clk) begin
    if (w_accept)
      r_hold <= in_data;
  end

endmodule

// File: tb/tb_upsample_param.sv
// Scoreboard bench for upsample_param: bursts expected per accepted sample are
// queued at accept time and popped as the DUT transfers outputs.
module tb_upsample_param;

  localparam int WIDTH = 32;
  localparam int LMAX  = 8;
  localparam int LW    = $clog2(LMAX) + 1;

  logic                    clk;
  logic                    rst;
  logic [LW-1:0]           l_factor;
  logic                    mode;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_data;
  logic                    out_first;
  logic                    out_last;

  typedef struct {
    logic signed [WIDTH-1:0] d;
    logic                    first;
    logic                    last;
  } exp_t;

  typedef struct {
    logic signed [WIDTH-1:0] d;
    logic [LW-1:0]           lf;
    logic                    m;
  } stim_t;

  exp_t  sb[$];
  stim_t stim[$];
  int    checks;
  int    errors;
  bit    rdy_pat;

  upsample_param #(.WIDTH(WIDTH), .LMAX(LMAX), .LW(LW)) dut (
    .clk      (clk),
    .rst      (rst),
    .l_factor (l_factor),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_first(out_first),
    .out_last (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_l(input int f);
    if (f == 0) return 1;
    if (f > LMAX) return LMAX;
    return f;
  endfunction

  task automatic add_stim(input logic signed [WIDTH-1:0] d, input int lf, input logic m);
    stim_t s;
    s.d  = d;
    s.lf = LW'(lf);
    s.m  = m;
    stim.push_back(s);
  endtask

  task automatic push_burst(input stim_t s);
    int   l;
    exp_t e;
    l = model_l(int'(s.lf));
    for (int k = 0; k < l; k++) begin
      e.d     = (k == 0 || s.m) ? s.d : '0;
      e.first = (k == 0);
      e.last  = (k == l - 1);
      sb.push_back(e);
    end
  endtask

  // Runs one cycle per falling edge: check registered outputs, drive the next
  // edge's inputs, check in_ready, then update the scoreboard for that edge.
  task automatic run_stream(input string name, input int budget, input bit partial);
    int  cyc;
    bit  done;
    bit  exp_rdy;
    cyc  = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      checks++;
      if (out_valid !== (sb.size() != 0)) begin
        errors++;
        $display("FAIL %s out_valid cyc %0d: got %b want %b", name, cyc, out_valid, sb.size() != 0);
      end
      if (sb.size() != 0 && out_valid === 1'b1) begin
        checks++;
        if (out_data !== sb[0].d || out_first !== sb[0].first || out_last !== sb[0].last) begin
          errors++;
          $display("FAIL %s output cyc %0d: got %h first %b last %b want %h first %b last %b",
                   name, cyc, out_data, out_first, out_last, sb[0].d, sb[0].first, sb[0].last);
        end
      end
      out_ready = rdy_pat ? (cyc % 3 == 0) : 1'b1;
      if (stim.size() != 0) begin
        in_valid = 1'b1;
        in_data  = stim[0].d;
        l_factor = stim[0].lf;
        mode     = stim[0].m;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      exp_rdy = (sb.size() == 0) || (sb.size() == 1 && out_ready);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL %s in_ready cyc %0d: got %b want %b", name, cyc, in_ready, exp_rdy);
      end
      if (out_ready && sb.size() != 0)
        void'(sb.pop_front());
      if (in_valid && exp_rdy) begin
        push_burst(stim[0]);
        void'(stim.pop_front());
      end
      cyc++;
      if (partial) begin
        done = (cyc >= budget);
      end else if (stim.size() == 0 && sb.size() == 0) begin
        done = 1'b1;
      end else if (cyc >= budget) begin
        errors++;
        $display("FAIL %s timeout: %0d outputs and %0d inputs pending", name, sb.size(), stim.size());
        sb.delete();
        stim.delete();
        done = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_data   = '0;
    l_factor  = '0;
    mode      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_first !== 1'b0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs: got v%b d%h f%b l%b want all zero", out_valid, out_data, out_first, out_last);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_zero_stuff();
    rdy_pat = 1'b0;
    add_stim(32'sd5, 4, 1'b0);
    add_stim(-32'sd3, 4, 1'b0);
    run_stream("zero_stuff", 200, 1'b0);
  endtask

  task automatic test_hold();
    rdy_pat = 1'b0;
    add_stim(32'sh7FFFFFFF, 3, 1'b1);
    add_stim(32'sh80000000, 3, 1'b1);
    run_stream("hold", 200, 1'b0);
  endtask

  task automatic test_l1_clamp();
    rdy_pat = 1'b0;
    for (int i = 0; i < 4; i++)
      add_stim(WIDTH'(i * 17 - 20), 1, 1'b0);
    add_stim(32'sd77, 0, 1'b1);
    add_stim(-32'sd78, 0, 1'b0);
    add_stim(32'sd1234, 15, 1'b1);
    add_stim(-32'sd9, 15, 1'b0);
    run_stream("l1_clamp", 200, 1'b0);
  endtask

  task automatic test_back_to_back_backpressure();
    rdy_pat = 1'b1;
    add_stim(32'sd100, 4, 1'b0);
    add_stim(-32'sd7, 4, 1'b1);
    add_stim(32'sd42, 2, 1'b1);
    run_stream("backpressure", 300, 1'b0);
    rdy_pat = 1'b0;
  endtask

  task automatic test_midburst_change();
    rdy_pat = 1'b0;
    add_stim(32'sd10, 4, 1'b0);
    add_stim(32'sd20, 2, 1'b1);
    add_stim(-32'sd30, 3, 1'b0);
    run_stream("midburst", 200, 1'b0);
  endtask

  task automatic test_async_reset();
    rdy_pat = 1'b0;
    add_stim(32'sd55, 4, 1'b1);
    run_stream("async_pre", 3, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_first !== 1'b0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL async_reset outputs: got v%b d%h f%b l%b want all zero", out_valid, out_data, out_first, out_last);
    end
    sb.delete();
    stim.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset idle after release: got %b want 0", out_valid);
    end
    add_stim(-32'sd66, 4, 1'b0);
    run_stream("async_post", 200, 1'b0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rdy_pat = 1'b0;
    rst     = 1'b1;
    test_reset();
    test_zero_stuff();
    test_hold();
    test_l1_clamp();
    test_back_to_back_backpressure();
    test_midburst_change();
    test_async_reset();
    run_stream("final_idle", 2, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/upsample_param.md
Name: upsample_param

Overview:
- Parametrised interpolating upsampler. Each accepted input sample produces L output samples.
  - Zero-stuff mode: the sample, then L-1 zeros.
  - Hold mode: the sample repeated L times (zero-order hold).
- L is selectable at run time up to LMAX.
- Sits between a sample source and an interpolation FIR. Valid/ready on both sides, so either side can stall.

Parameters:
- WIDTH, 32, signed sample width in bits.
- LMAX, 8, maximum upsampling factor (>=2).
- LW, $clog2(LMAX)+1, width of the factor input.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- l_factor  in  LW  requested upsampling factor; sampled only at input accept.
- mode  in  1  0 = zero-stuff, 1 = zero-order hold; sampled only at input accept.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept an input this cycle.
- in_data  in  WIDTH  signed input sample.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the output this cycle.
- out_data  out  WIDTH  signed output sample.
- out_first  out  1  high on phase 0 (the original sample) of each burst.
- out_last  out  1  high on phase L-1 of each burst.

Behaviour:
- Reset (rst low, async): out_valid=0, out_data=0, out_first=0, out_last=0, phase=0, latched L=1, latched mode=0. in_ready is 1 once reset is released.
- Factor clamp at accept: l_factor=0 becomes 1; l_factor>LMAX becomes LMAX. The clamped L and mode are latched into burst registers; the held sample is latched as well.
- Mid-burst input changes: l_factor and mode changes have no effect on the burst in progress. They take effect at the next accept.
- Input accept occurs when in_valid && in_ready.
- in_ready = !out_valid || (out_ready && out_last). This is combinational from the registered state plus out_ready.
- Output transfer occurs when out_valid && out_ready.
- Latency: on an accept at edge N, out_valid=1 after edge N, carrying phase 0: out_data=in_data, out_first=1, out_last=(L==1).
- Burst FSM, states IDLE and BURST:
  - IDLE -> BURST on accept. phase=0.
  - BURST, transfer with phase<L-1: phase increments. out_data = 0 in zero-stuff mode, the held sample in hold mode. out_first=0. out_last=(phase+1==L-1).
  - BURST, transfer with phase==L-1 and a simultaneous accept: reload immediately, no bubble, phase=0. Sustained throughput is 1 output/cycle for every L, including L=1.
  - BURST, transfer with phase==L-1 and no accept: -> IDLE, out_valid=0, out_data holds its last value.
- Stall: while out_valid && !out_ready, out_data, out_first, out_last and phase hold. Nothing advances.
- Arithmetic: no gain or scaling. Samples pass bit-exact; zero is all-zeros WIDTH bits.
- Phase counter width is LW. It never exceeds L-1 and wraps to 0 only via reload.
- Reset mid-burst aborts the burst; the held sample is discarded. The first post-reset output comes from the first post-reset accept.

Test Plan:
- Reset, L=4, zero-stuff, out_ready=1, input stream 5,-3 back-to-back:
  - out_data = 5,0,0,0,-3,0,0,0 on consecutive cycles.
  - out_first on the 5 and the -3; out_last on the 4th and 8th outputs.
  - in_ready=1 only on cycles where an accept is legal.
  - 0 appears one cycle after the first accept.
- L=3, hold mode, input 0x7FFFFFFF then 0x80000000:
  - out_data = 7FFFFFFF x3, then 80000000 x3.
  - No bubble at the burst boundary; sign is preserved.
- L=1, continuous in_valid, out_ready=1:
  - 1 output per cycle, each with out_first=out_last=1.
  - l_factor=0 also behaves as L=1; l_factor=15 clamps to LMAX=8 outputs.
- Backpressure, L=4, out_ready toggling 1,0,0,1,...:
  - out_data and phase hold while stalled.
  - in_ready=0 until the out_last transfer.
  - Total of exactly 4 outputs per input.
- l_factor changed from 4 to 2 at phase 1 of a burst:
  - Current burst still emits 4 outputs.
  - The next sample emits 2.
- rst asserted asynchronously at phase 2 of an L=4 burst:
  - out_valid drops immediately, without waiting for a clock.
  - After release, the first output is the next accepted sample with out_first=1.
